// File: rtl/lpif_txrx_x8_asym2_full_slave_gearbox.sv
`default_nettype none
// ============================================================================
// Module   : lpif_txrx_x8_asym2_full_slave_gearbox
// Brief    : Slave-side gearbox between 580-bit logic-link FIFO words and a
//            single-flit LPIF bus (rx serializer, tx packer with idle flush).
// Revision : 1.0 - initial release
// ============================================================================
module lpif_txrx_x8_asym2_full_slave_gearbox #(
    parameter int NSLICE        = 4,
    parameter int RX_DEPTH      = 2,
    parameter int FLUSH_TIMEOUT = 8
) (
    input  logic                  clk_wr,
    input  logic                  rst_wr_n,
    input  logic [NSLICE*145-1:0] rxfifo_word,
    input  logic                  rxfifo_word_valid,
    output logic                  rxfifo_word_ready,
    output logic [3:0]            ustrm_state,
    output logic [1:0]            ustrm_protid,
    output logic [127:0]          ustrm_data,
    output logic                  ustrm_dvalid,
    output logic [7:0]            ustrm_crc,
    output logic                  ustrm_crc_valid,
    output logic                  ustrm_valid,
    input  logic [3:0]            dstrm_state,
    input  logic [1:0]            dstrm_protid,
    input  logic [127:0]          dstrm_data,
    input  logic                  dstrm_dvalid,
    input  logic [7:0]            dstrm_crc,
    input  logic                  dstrm_crc_valid,
    input  logic                  dstrm_valid,
    output logic                  dstrm_trdy,
    output logic [NSLICE*145-1:0] txfifo_word,
    output logic                  txfifo_word_valid,
    input  logic                  txfifo_word_ready
);
    localparam int         c_SW        = 145;
    localparam int         c_WW        = NSLICE * c_SW;
    localparam int         c_PW        = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam int         c_CW        = $clog2(RX_DEPTH + 1);
    localparam logic [1:0] c_LAST      = 2'(NSLICE - 1);
    localparam logic [7:0] c_IDLE_LAST = 8'(FLUSH_TIMEOUT - 1);

    // ------------------------------------------------------------------ rx
    logic [c_WW-1:0]             r_mem [RX_DEPTH];
    logic [c_PW-1:0]             r_rd;
    logic [c_PW-1:0]             r_wr;
    logic [c_PW-1:0]             w_rd_next;
    logic [c_CW-1:0]             r_count;
    logic [c_CW-1:0]             w_count_next;
    logic [1:0]                  r_sel;
    logic [1:0]                  w_sel_next;
    logic                        r_rx_ready;
    logic                        w_push;
    logic                        w_pop;
    logic [c_WW-1:0]             w_head_word;
    logic [NSLICE-1:0][c_SW-1:0] w_head_slices;
    logic [c_SW-1:0]             r_ustrm;

    assign w_push       = rxfifo_word_valid && r_rx_ready;
    assign w_pop        = (r_count != '0) && (r_sel == c_LAST);
    assign w_count_next = r_count + c_CW'(w_push) - c_CW'(w_pop);
    assign w_rd_next    = r_rd + c_PW'(w_pop);
    assign w_sel_next   = (r_count != '0) ? r_sel + 2'd1 : r_sel;

    // The output register shows the slice due next cycle, so a word arriving
    // into an empty buffer bypasses the storage array.
    assign w_head_word   = (w_push && (r_count == c_CW'(w_pop))) ? rxfifo_word : r_mem[w_rd_next];
    assign w_head_slices = w_head_word;

    always_ff @(posedge clk_wr) begin
        if (w_push) r_mem[r_wr] <= rxfifo_word;
    end

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            r_count    <= '0;
            r_rd       <= '0;
            r_wr       <= '0;
            r_sel      <= '0;
            r_rx_ready <= 1'b1;
            r_ustrm    <= '0;
        end else begin
            r_count    <= w_count_next;
            r_rd       <= w_rd_next;
            r_wr       <= r_wr + c_PW'(w_push);
            r_sel      <= w_sel_next;
            r_rx_ready <= (w_count_next < c_CW'(RX_DEPTH));
            if (w_count_next != '0) begin
                r_ustrm <= w_head_slices[w_sel_next];
            end else begin
                // Idle: drop the qualifiers, keep the payload fields steady.
                r_ustrm[144] <= 1'b0;
                r_ustrm[143] <= 1'b0;
                r_ustrm[134] <= 1'b0;
            end
        end
    end

    assign rxfifo_word_ready = r_rx_ready;
    assign ustrm_state       = r_ustrm[3:0];
    assign ustrm_protid      = r_ustrm[5:4];
    assign ustrm_data        = r_ustrm[133:6];
    assign ustrm_dvalid      = r_ustrm[134];
    assign ustrm_crc         = r_ustrm[142:135];
    assign ustrm_crc_valid   = r_ustrm[143];
    assign ustrm_valid       = r_ustrm[144];

    // ------------------------------------------------------------------ tx
    logic [NSLICE-1:0][c_SW-1:0] r_asm;
    logic [NSLICE-1:0][c_SW-1:0] w_cand;
    logic                        r_asm_full;
    logic [1:0]                  r_idx;
    logic [7:0]                  r_idle;
    logic [c_WW-1:0]             r_tx_word;
    logic                        r_tx_valid;
    logic [c_SW-1:0]             w_flit;
    logic [5:0]                  w_last_hdr;
    logic [c_SW-1:0]             w_pad;
    logic                        w_out_free;
    logic                        w_accept;
    logic                        w_timeout;
    logic                        w_complete;

    assign w_flit     = {dstrm_valid, dstrm_crc_valid, dstrm_crc, dstrm_dvalid,
                         dstrm_data, dstrm_protid, dstrm_state};
    assign w_out_free = !r_tx_valid || txfifo_word_ready;
    assign dstrm_trdy = !(r_asm_full && !w_out_free);
    assign w_accept   = dstrm_valid && dstrm_trdy;
    assign w_timeout  = !w_accept && (r_idx != 2'd0) && (r_idle == c_IDLE_LAST);
    assign w_complete = (w_accept && (r_idx == c_LAST)) || w_timeout;

    // Padding slots carry the last real slot's state/protid and nothing else.
    assign w_last_hdr = r_asm[r_idx - 2'd1][5:0];
    assign w_pad      = {139'd0, w_last_hdr};

    always_comb begin
        w_cand = r_asm;
        if (w_accept) w_cand[r_idx] = w_flit;
        if (w_timeout) begin
            for (int s = 0; s < NSLICE; s++) begin
                if (2'(s) >= r_idx) w_cand[s] = w_pad;
            end
        end
    end

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            r_asm      <= '0;
            r_asm_full <= 1'b0;
            r_idx      <= '0;
            r_idle     <= '0;
            r_tx_word  <= '0;
            r_tx_valid <= 1'b0;
        end else begin
            if (r_asm_full && w_out_free) begin
                r_tx_word  <= r_asm;
                r_tx_valid <= 1'b1;
                r_asm_full <= 1'b0;
            end else if (w_complete && w_out_free) begin
                r_tx_word  <= w_cand;
                r_tx_valid <= 1'b1;
            end else begin
                if (w_complete) r_asm_full <= 1'b1;
                if (txfifo_word_ready) r_tx_valid <= 1'b0;
            end

            if (w_accept || w_timeout) r_asm <= w_cand;

            if (w_accept)       r_idx <= r_idx + 2'd1;
            else if (w_timeout) r_idx <= 2'd0;

            if (w_accept || w_timeout) r_idle <= '0;
            else if (r_idx != 2'd0)    r_idle <= r_idle + 8'd1;
        end
    end

    assign txfifo_word       = r_tx_word;
    assign txfifo_word_valid = r_tx_valid;

endmodule
`default_nettype wire

// File: tb/tb_lpif_txrx_x8_asym2_full_slave_gearbox.sv
`default_nettype none
// ============================================================================
// Module   : tb_lpif_txrx_x8_asym2_full_slave_gearbox
// Brief    : Self-checking bench: flit tables, rx/tx scoreboards, corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lpif_txrx_x8_asym2_full_slave_gearbox;

    typedef struct {
        logic [3:0]   state;
        logic [1:0]   protid;
        logic [127:0] data;
        logic         dvalid;
        logic [7:0]   crc;
        logic         crc_valid;
        logic         valid;
    } flit_t;

    logic         clk_wr = 1'b0;
    logic         rst_wr_n = 1'b0;
    logic [579:0] rxfifo_word;
    logic         rxfifo_word_valid;
    logic         rxfifo_word_ready;
    logic [3:0]   ustrm_state;
    logic [1:0]   ustrm_protid;
    logic [127:0] ustrm_data;
    logic         ustrm_dvalid;
    logic [7:0]   ustrm_crc;
    logic         ustrm_crc_valid;
    logic         ustrm_valid;
    logic [3:0]   dstrm_state;
    logic [1:0]   dstrm_protid;
    logic [127:0] dstrm_data;
    logic         dstrm_dvalid;
    logic [7:0]   dstrm_crc;
    logic         dstrm_crc_valid;
    logic         dstrm_valid;
    logic         dstrm_trdy;
    logic [579:0] txfifo_word;
    logic         txfifo_word_valid;
    logic         txfifo_word_ready;

    lpif_txrx_x8_asym2_full_slave_gearbox dut (
        .clk_wr            (clk_wr),
        .rst_wr_n          (rst_wr_n),
        .rxfifo_word       (rxfifo_word),
        .rxfifo_word_valid (rxfifo_word_valid),
        .rxfifo_word_ready (rxfifo_word_ready),
        .ustrm_state       (ustrm_state),
        .ustrm_protid      (ustrm_protid),
        .ustrm_data        (ustrm_data),
        .ustrm_dvalid      (ustrm_dvalid),
        .ustrm_crc         (ustrm_crc),
        .ustrm_crc_valid   (ustrm_crc_valid),
        .ustrm_valid       (ustrm_valid),
        .dstrm_state       (dstrm_state),
        .dstrm_protid      (dstrm_protid),
        .dstrm_data        (dstrm_data),
        .dstrm_dvalid      (dstrm_dvalid),
        .dstrm_crc         (dstrm_crc),
        .dstrm_crc_valid   (dstrm_crc_valid),
        .dstrm_valid       (dstrm_valid),
        .dstrm_trdy        (dstrm_trdy),
        .txfifo_word       (txfifo_word),
        .txfifo_word_valid (txfifo_word_valid),
        .txfifo_word_ready (txfifo_word_ready)
    );

    always #5 clk_wr = ~clk_wr;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [144:0] rx_exp_q [$];
    logic [579:0] tx_exp_q [$];
    logic [579:0] tx_got [$];
    int           rx_seen  = 0;
    int           tx_seen  = 0;
    int           run      = 0;
    int           last_run = 0;
    logic [144:0] mon_exp;
    logic [579:0] mon_wexp;
    flit_t        rx_tbl [12];
    flit_t        tx_tbl [8];

    function automatic logic [144:0] pf(input flit_t f);
        return {f.valid, f.crc_valid, f.crc, f.dvalid, f.data, f.protid, f.state};
    endfunction

    task automatic chk(input string nm, input logic [579:0] act, input logic [579:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitors, sampled on the falling edge.
    always @(negedge clk_wr) begin
        if (!rst_wr_n) begin
            run = 0;
        end else begin
            if (ustrm_valid) begin
                rx_seen++;
                run++;
                if (rx_exp_q.size() == 0) chk("rx_unexpected_subflit", 1, 0);
                else begin
                    mon_exp = rx_exp_q.pop_front();
                    chk("rx_subflit", {ustrm_valid, ustrm_crc_valid, ustrm_crc, ustrm_dvalid,
                                       ustrm_data, ustrm_protid, ustrm_state}, mon_exp);
                end
            end else begin
                if (run != 0) last_run = run;
                run = 0;
            end
            if (txfifo_word_valid && txfifo_word_ready) begin
                tx_seen++;
                tx_got.push_back(txfifo_word);
                if (tx_exp_q.size() == 0) chk("tx_unexpected_word", 1, 0);
                else begin
                    mon_wexp = tx_exp_q.pop_front();
                    chk("tx_word", txfifo_word, mon_wexp);
                end
            end
        end
    end

    task automatic send_rx(input logic [579:0] w, output int waits);
        logic acc;
        acc = 1'b0;
        waits = 0;
        rxfifo_word = w;
        rxfifo_word_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk_wr);
            acc = rxfifo_word_ready;
            @(posedge clk_wr);
            #1;
            if (acc) break;
            waits++;
        end
        if (!acc) chk("rx_accept_timeout", acc, 1);
    endtask

    task automatic send_tx(input flit_t f);
        logic acc;
        acc = 1'b0;
        dstrm_state = f.state;  dstrm_protid = f.protid; dstrm_data = f.data;
        dstrm_dvalid = f.dvalid; dstrm_crc = f.crc; dstrm_crc_valid = f.crc_valid;
        dstrm_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk_wr);
            acc = dstrm_trdy;
            @(posedge clk_wr);
            #1;
            if (acc) break;
        end
        if (!acc) chk("tx_accept_timeout", acc, 1);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 200; k++) begin
            @(negedge clk_wr);
            if (rx_exp_q.size() == 0 && tx_exp_q.size() == 0) break;
        end
        @(posedge clk_wr);
        #1;
        chk("rx_queue_drained", rx_exp_q.size(), 0);
        chk("tx_queue_drained", tx_exp_q.size(), 0);
    endtask

    logic [579:0] w;
    logic [144:0] s [4];
    int           waits [3];
    int           c;
    int           rx0;
    int           tx0;
    flit_t        f;

    initial begin
        rxfifo_word = '0; rxfifo_word_valid = 1'b0;
        dstrm_state = '0; dstrm_protid = '0; dstrm_data = '0; dstrm_dvalid = 1'b0;
        dstrm_crc = '0; dstrm_crc_valid = 1'b0; dstrm_valid = 1'b0;
        txfifo_word_ready = 1'b1;

        for (int i = 0; i < 12; i++) begin
            rx_tbl[i].state     = 4'(i + 2);
            rx_tbl[i].protid    = 2'(i);
            rx_tbl[i].data      = {4{32'hA500_0000 + 32'(i * 7)}};
            rx_tbl[i].dvalid    = (i % 3) != 0;
            rx_tbl[i].crc       = 8'(8'h30 + i);
            rx_tbl[i].crc_valid = i[0];
            rx_tbl[i].valid     = 1'b1;
        end
        for (int i = 0; i < 8; i++) begin
            tx_tbl[i].state     = 4'h3;
            tx_tbl[i].protid    = 2'(i);
            tx_tbl[i].data      = 128'(i);
            tx_tbl[i].dvalid    = 1'b1;
            tx_tbl[i].crc       = 8'(8'hC0 + i);
            tx_tbl[i].crc_valid = 1'b1;
            tx_tbl[i].valid     = 1'b1;
        end

        // Reset state
        repeat (3) @(posedge clk_wr);
        #2;
        chk("rst_ustrm_valid", ustrm_valid, 0);
        chk("rst_ustrm_data", ustrm_data, 0);
        chk("rst_rx_ready", rxfifo_word_ready, 1);
        chk("rst_dstrm_trdy", dstrm_trdy, 1);
        chk("rst_tx_valid", txfifo_word_valid, 0);
        chk("rst_tx_word", txfifo_word, 0);
        @(negedge clk_wr);
        rst_wr_n = 1'b1;
        @(posedge clk_wr);
        #1;

        // Single rx word: slices on N+1..N+4, idle on N+5 with data held
        for (int i = 0; i < 4; i++) begin
            f.state = 4'(i + 1); f.protid = 2'(i); f.data = {16{8'(8'h11 * (i + 1))}};
            f.dvalid = 1'b1; f.crc = 8'(i); f.crc_valid = 1'b1; f.valid = 1'b1;
            s[i] = pf(f);
            rx_exp_q.push_back(s[i]);
        end
        w = {s[3], s[2], s[1], s[0]};
        send_rx(w, c);
        rxfifo_word_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk_wr);
            chk("single_word_valid", ustrm_valid, (k <= 4) ? 1 : 0);
        end
        chk("idle_data_hold", ustrm_data, {16{8'h44}});
        chk("idle_dvalid_low", ustrm_dvalid, 0);
        @(posedge clk_wr);
        #1;
        chk("single_word_run", last_run, 4);
        wait_drain();

        // Three back-to-back rx words from the table
        for (int i = 0; i < 12; i++) rx_exp_q.push_back(pf(rx_tbl[i]));
        for (int j = 0; j < 3; j++) begin
            w = {pf(rx_tbl[4*j+3]), pf(rx_tbl[4*j+2]), pf(rx_tbl[4*j+1]), pf(rx_tbl[4*j])};
            send_rx(w, waits[j]);
        end
        rxfifo_word_valid = 1'b0;
        chk("b2b_word0_wait", waits[0], 0);
        chk("b2b_word1_wait", waits[1], 0);
        chk("b2b_word2_wait", waits[2], 3);
        wait_drain();
        repeat (2) @(posedge clk_wr);
        #1;
        chk("b2b_gapless_run", last_run, 12);

        // Eight tx flits, output always ready
        tx_got.delete();
        for (int i = 0; i < 8; i++) begin
            if (i % 4 == 3)
                tx_exp_q.push_back({pf(tx_tbl[i]), pf(tx_tbl[i-1]), pf(tx_tbl[i-2]), pf(tx_tbl[i-3])});
            send_tx(tx_tbl[i]);
        end
        dstrm_valid = 1'b0;
        wait_drain();
        chk("tx_word_count", tx_got.size(), 2);
        if (tx_got.size() > 0) begin
            w = tx_got[0];
            chk("tx_w0_data_slot0", w[6+:128], 0);
            chk("tx_w0_data_slot1", w[151+:128], 1);
            chk("tx_w0_data_slot2", w[296+:128], 2);
            chk("tx_w0_data_slot3", w[441+:128], 3);
            chk("tx_w0_valid_bits", {w[579], w[434], w[289], w[144]}, 4'hF);
            chk("tx_w0_state_slot3", w[435+:4], 3);
        end

        // Tx backpressure: output blocked for 10 cycles while 8 flits offered
        txfifo_word_ready = 1'b0;
        tx_exp_q.push_back({pf(tx_tbl[3]), pf(tx_tbl[2]), pf(tx_tbl[1]), pf(tx_tbl[0])});
        tx_exp_q.push_back({pf(tx_tbl[7]), pf(tx_tbl[6]), pf(tx_tbl[5]), pf(tx_tbl[4])});
        fork
            begin
                for (int i = 0; i < 8; i++) send_tx(tx_tbl[i]);
                dstrm_valid = 1'b0;
                @(negedge clk_wr);
                chk("bp_trdy_low", dstrm_trdy, 0);
                chk("bp_tx_valid_held", txfifo_word_valid, 1);
            end
            begin
                repeat (10) @(posedge clk_wr);
                #1;
                txfifo_word_ready = 1'b1;
            end
        join
        wait_drain();
        chk("bp_trdy_recovered", dstrm_trdy, 1);

        // Idle flush after two flits
        f.state = 4'h5; f.protid = 2'b01; f.data = 128'hDEAD; f.dvalid = 1'b1;
        f.crc = 8'h5A; f.crc_valid = 1'b1; f.valid = 1'b1;
        s[0] = pf(f);
        send_tx(f);
        f.protid = 2'b10; f.data = 128'hBEEF; f.crc = 8'hA5;
        s[1] = pf(f);
        s[2] = {139'd0, 2'b10, 4'h5};
        tx_exp_q.push_back({s[2], s[2], s[1], s[0]});
        send_tx(f);
        dstrm_valid = 1'b0;
        c = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk_wr);
            #1;
            c++;
            if (txfifo_word_valid) break;
        end
        chk("flush_latency", c, 8);
        wait_drain();

        // Reset mid rx word and mid tx assembly
        send_tx(tx_tbl[0]);
        send_tx(tx_tbl[1]);
        dstrm_valid = 1'b0;
        for (int i = 0; i < 4; i++) rx_exp_q.push_back(pf(rx_tbl[i]));
        send_rx({pf(rx_tbl[3]), pf(rx_tbl[2]), pf(rx_tbl[1]), pf(rx_tbl[0])}, c);
        rxfifo_word_valid = 1'b0;
        @(posedge clk_wr);
        #3;
        rst_wr_n = 1'b0;
        #1;
        chk("midrst_ustrm_valid", ustrm_valid, 0);
        chk("midrst_ustrm_data", ustrm_data, 0);
        chk("midrst_rx_ready", rxfifo_word_ready, 1);
        chk("midrst_trdy", dstrm_trdy, 1);
        chk("midrst_tx_valid", txfifo_word_valid, 0);
        rx_exp_q.delete();
        tx_exp_q.delete();
        repeat (2) @(posedge clk_wr);
        @(negedge clk_wr);
        rst_wr_n = 1'b1;
        rx0 = rx_seen;
        tx0 = tx_seen;
        repeat (20) @(posedge clk_wr);
        #1;
        chk("postrst_no_subflit", rx_seen - rx0, 0);
        chk("postrst_no_txword", tx_seen - tx0, 0);

        // Recovery: one more rx word after reset
        for (int i = 4; i < 8; i++) rx_exp_q.push_back(pf(rx_tbl[i]));
        send_rx({pf(rx_tbl[7]), pf(rx_tbl[6]), pf(rx_tbl[5]), pf(rx_tbl[4])}, c);
        rxfifo_word_valid = 1'b0;
        wait_drain();
        chk("postrst_rx_count", rx_seen - rx0, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/lpif_txrx_x8_asym2_full_slave_gearbox.md
Name: lpif_txrx_x8_asym2_full_slave_gearbox

Overview:
- Slave-end counterpart to the x8 asym2 quarter-rate master word packing on the LPIF-over-AIB link.
- Rx path: accepts 580-bit words of four 145-bit sub-flits from the rx FIFO and serializes them, one sub-flit per clock, onto a single-flit slave LPIF upstream bus.
- Tx path: collects single downstream flits into four-flit 580-bit words for the tx FIFO, with backpressure and an idle flush.
- Sits between the slave-side logic-link FIFOs and the slave LPIF adapter.

Parameters:
- NSLICE, 4, sub-flits per word (fixed; word = NSLICE*145 = 580).
- RX_DEPTH, 2, rx word buffer entries (power of 2, ≥2).
- FLUSH_TIMEOUT, 8, idle cycles before a partial tx word is padded and emitted (1..255).

Ports:
- clk_wr  input  1  single clock for both paths.
- rst_wr_n  input  1  asynchronous active-low reset.
- rxfifo_word  input  580  packed word from the rx FIFO.
- rxfifo_word_valid  input  1  word present.
- rxfifo_word_ready  output  1  word accepted when valid&&ready.
- ustrm_state  output  4  sub-flit state.
- ustrm_protid  output  2  sub-flit protocol id.
- ustrm_data  output  128  sub-flit data.
- ustrm_dvalid  output  1  sub-flit data valid.
- ustrm_crc  output  8  sub-flit CRC.
- ustrm_crc_valid  output  1  sub-flit CRC valid.
- ustrm_valid  output  1  sub-flit valid.
- dstrm_state, dstrm_protid, dstrm_data, dstrm_dvalid, dstrm_crc, dstrm_crc_valid, dstrm_valid  input  4/2/128/1/8/1/1  downstream flit; captured when dstrm_valid&&dstrm_trdy.
- dstrm_trdy  output  1  tx assembly can accept a flit.
- txfifo_word  output  580  packed word to the tx FIFO.
- txfifo_word_valid  output  1  word pending.
- txfifo_word_ready  input  1  tx FIFO accepts.

Behaviour:
- Sub-flit i layout, base b=145*i:
  - state [b+0+:4], protid [b+4+:2], data [b+6+:128], dvalid [b+134]
  - crc [b+135+:8], crc_valid [b+143], valid [b+144].
  - Slice 0 occupies the lowest bits and is sent or emitted first.
- Reset values:
  - All ustrm_* = 0; txfifo_word = 0; txfifo_word_valid = 0.
  - rxfifo_word_ready = 1; dstrm_trdy = 1.
  - Rx buffer empty, slice index 0; tx slot index 0, idle counter 0.
- Reset asserted mid-operation discards buffered and partially assembled words with no flush.
- Rx buffer and index:
  - RX_DEPTH-entry FIFO of words.
  - rxfifo_word_ready = (count < RX_DEPTH), registered.
  - Push and pop in the same cycle keeps count unchanged and is allowed when full.
  - 2-bit slice index sel.
- Rx output (registered):
  - Each cycle the buffer is non-empty: drive slice sel of the head word onto ustrm_*, then sel++.
  - When sel==3: pop the head and set sel=0.
  - Latency: a word accepted at cycle N drives slice 0 at N+1, provided the buffer was empty.
  - Back-to-back words stream with no bubble.
- Rx empty cycle:
  - ustrm_valid, ustrm_dvalid, ustrm_crc_valid = 0.
  - state/protid/data/crc hold their last values.
- Rx sustained rate: one word per 4 cycles without stall.
- Tx assembly:
  - 2-bit slot index; 580-bit assembly register.
  - An accepted flit writes slot idx, then idx++.
  - After slot 3 is written, the word moves to the output register, provided it is empty or being drained that cycle; idx returns to 0.
- Tx output register:
  - txfifo_word_valid holds and txfifo_word is stable until txfifo_word_ready.
  - dstrm_trdy = 0 only while the assembly register is complete (4 slots) and the output register is full and not draining.
- Tx flush:
  - Idle counter increments on each cycle with idx≠0 and no accepted flit; it clears on any accepted flit or on emit.
  - At FLUSH_TIMEOUT, pad the remaining slots: valid/dvalid/crc_valid/data/crc = 0, state/protid = copy of the last written slot. Then transfer as a complete word.
  - No flush while idx==0.
- Simultaneous completion and drain in the same cycle: transfer occurs with no stall.

Test Plan:
- Single rx word with slices carrying data 0x11..,0x22..,0x33..,0x44.. and valid=1 each, after reset → ustrm_data shows the four values on cycles N+1..N+4 with ustrm_valid=1; cycle N+5 ustrm_valid=0.
- Three rx words back-to-back with valid held → rxfifo_word_ready drops after 2 are buffered; 12 consecutive valid sub-flits with no gap; ready reasserts when the first word pops.
- Eight tx flits, state=0x3, data=index, txfifo_word_ready=1 → two words; word 0 has data 0,1,2,3 at bits 6, 151, 296, 441 and valid bits 144/289/434/579 = 1.
- Tx with txfifo_word_ready=0 for 10 cycles while 8 flits are offered → dstrm_trdy=0 after flit 8 is captured; no flit lost; both words emitted in order once ready rises.
- Tx flush: 2 flits (state=0x5) then idle with FLUSH_TIMEOUT=8 → word emitted 8 cycles after the last flit; slots 2,3 have valid=0, data=0, state=0x5.
- Assert rst_wr_n low mid-rx word and mid-tx assembly → all outputs return to reset values asynchronously; no sub-flit or partial word emitted after release.
